vehicle_plant_model: RTL and testbench

Closed-loop vehicle plant model for the cruise-control bench. It is the driven end of the `Control_Unit` interface: it consumes `accelerate_car` and `unlock_doors`, and it produces the `car_speed` and `leading_distance` that the control unit reads. Internally it runs a tick prescaler, a four-state motion FSM and saturating speed/gap integrators. Its outputs connect directly to `Control_Unit` inputs, so the bench runs as a closed loop instead of scripted stimulus.

---
 rtl/vehicle_plant_model.sv | 214 +++++++++++++++++++++
 tb/tb_vehicle_plant_model.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_plant_model.sv
// -----------------------------------------------------------------------------
// vehicle_plant_model
//
// Closed-loop vehicle plant for the cruise-control bench. It accepts the
// throttle and door requests from the control unit and returns its own speed
// and the gap to a leading vehicle. The plant advances once per prescaler tick.
// A four-state motion FSM selects how the speed integrator moves. The gap
// integrator follows the relative speed to the lead vehicle.
//
// Ports
//   CLK              in   1  clock, rising edge
//   rst              in   1  synchronous active-high reset
//   enable           in   1  run; low freezes prescaler and all state
//   accelerate_car   in   1  throttle request
//   unlock_doors     in   1  door-unlock request (forces a stop)
//   lead_speed       in   8  lead vehicle speed, km/h
//   car_speed        out  8  own speed, km/h (registered)
//   leading_distance out  7  gap to lead vehicle, m (registered, 0..127)
//   plant_state      out  2  PARKED=0, ACCEL=1, COAST=2, BRAKE=3
//   collision        out  1  sticky crash flag, cleared only by rst
// -----------------------------------------------------------------------------
module vehicle_plant_model #(
    parameter int TICK_DIV   = 4,
    parameter int ACCEL_STEP = 10,
    parameter int COAST_STEP = 2,
    parameter int BRAKE_STEP = 20,
    parameter int MAX_SPEED  = 200,
    parameter int INIT_DIST  = 70,
    parameter int BRAKE_DIST = 20,
    parameter int DIST_SHIFT = 3
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       enable,
    input  logic       accelerate_car,
    input  logic       unlock_doors,
    input  logic [7:0] lead_speed,
    output logic [7:0] car_speed,
    output logic [6:0] leading_distance,
    output logic [1:0] plant_state,
    output logic       collision
);

    typedef enum logic [1:0] {
        ST_PARKED = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_COAST  = 2'd2,
        ST_BRAKE  = 2'd3
    } state_t;

    // A one-bit counter is kept for TICK_DIV=1; it simply never leaves 0.
    localparam int             CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    state_t      state_q, state_d;
    logic [7:0]  speed_q, speed_d;
    logic [6:0]  dist_q, dist_d;
    logic        coll_q, coll_d;

    logic              brake_req;
    logic [8:0]        accel_sum;
    logic signed [8:0] rel_speed;
    logic signed [8:0] gap_delta;
    logic signed [9:0] gap_sum;
    logic [6:0]        gap_next;

    // ---------------------------------------------------------------------
    // Prescaler
    // ---------------------------------------------------------------------
    assign tick = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Speed integrator: step chosen by the state held before this tick
    // ---------------------------------------------------------------------
    // Nine bits so the overshoot past MAX_SPEED near 255 cannot wrap.
    assign accel_sum = {1'b0, speed_q} + 9'(ACCEL_STEP);

    always_comb begin
        speed_d = speed_q;
        if (tick) begin
            unique case (state_q)
                ST_PARKED: speed_d = '0;
                ST_ACCEL: begin
                    if (accel_sum > 9'(MAX_SPEED)) begin
                        speed_d = 8'(MAX_SPEED);
                    end else begin
                        speed_d = accel_sum[7:0];
                    end
                end
                ST_COAST: begin
                    if (speed_q >= 8'(COAST_STEP)) begin
                        speed_d = speed_q - 8'(COAST_STEP);
                    end else begin
                        speed_d = '0;
                    end
                end
                ST_BRAKE: begin
                    if (speed_q >= 8'(BRAKE_STEP)) begin
                        speed_d = speed_q - 8'(BRAKE_STEP);
                    end else begin
                        speed_d = '0;
                    end
                end
                default: speed_d = speed_q;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Gap integrator: arithmetic shift floors negative closing speeds
    // ---------------------------------------------------------------------
    assign rel_speed = $signed({1'b0, lead_speed}) - $signed({1'b0, speed_q});
    assign gap_delta = rel_speed >>> DIST_SHIFT;
    assign gap_sum   = $signed({3'b000, dist_q}) + $signed({gap_delta[8], gap_delta});

    always_comb begin
        if (gap_sum < 10'sd0) begin
            gap_next = '0;
        end else if (gap_sum > 10'sd127) begin
            gap_next = 7'd127;
        end else begin
            gap_next = gap_sum[6:0];
        end
    end

    assign dist_d = tick ? gap_next : dist_q;

    // Contact only counts if we were still moving when the gap closed.
    assign coll_d = coll_q | (tick & (gap_next == 7'd0) & (speed_q != 8'd0));

    // ---------------------------------------------------------------------
    // Motion FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_PARKED;
            cnt_q   <= '0;
            speed_q <= '0;
            dist_q  <= 7'(INIT_DIST);
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            dist_q  <= dist_d;
            coll_q  <= coll_d;
        end
    end

    // ---------------------------------------------------------------------
    // Motion FSM: next-state logic (registered speed/gap/flag only)
    // ---------------------------------------------------------------------
    assign brake_req = coll_q | unlock_doors | (int'(dist_q) < BRAKE_DIST);

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_PARKED: begin
                    if (accelerate_car && !unlock_doors && !coll_q) begin
                        state_d = ST_ACCEL;
                    end
                end
                ST_ACCEL: begin
                    if (brake_req) begin
                        state_d = ST_BRAKE;
                    end else if (!accelerate_car) begin
                        state_d = ST_COAST;
                    end
                end
                ST_COAST: begin
                    if (brake_req) begin
                        state_d = ST_BRAKE;
                    end else if (accelerate_car) begin
                        state_d = ST_ACCEL;
                    end else if (speed_q == 8'd0) begin
                        state_d = ST_PARKED;
                    end
                end
                ST_BRAKE: begin
                    if (speed_q == 8'd0) begin
                        state_d = ST_PARKED;
                    end else if (accelerate_car && !brake_req) begin
                        state_d = ST_ACCEL;
                    end
                end
                default: state_d = ST_PARKED;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Motion FSM: outputs, all straight from registers
    // ---------------------------------------------------------------------
    always_comb begin
        plant_state      = state_q;
        car_speed        = speed_q;
        leading_distance = dist_q;
        collision        = coll_q;
    end

endmodule

// File: tb/tb_vehicle_plant_model.sv
// -----------------------------------------------------------------------------
// tb_vehicle_plant_model
//
// Directed bench for vehicle_plant_model. Instance dut_a uses the default
// parameters. Instance dut_b sets BRAKE_DIST=0, so the gap never forces a
// brake and a collision can be provoked. Both instances share the stimulus.
// Expected values are hand-derived from the plant rules. The tick-level
// sequences are worked through in the comments next to each phase.
// -----------------------------------------------------------------------------
module tb_vehicle_plant_model;

    localparam int TICK = 4;
    localparam int ST_PARKED = 0;
    localparam int ST_ACCEL  = 1;
    localparam int ST_BRAKE  = 3;

    logic       CLK = 1'b0;
    logic       rst;
    logic       enable;
    logic       accelerate_car;
    logic       unlock_doors;
    logic [7:0] lead_speed;

    logic [7:0] speed_a, speed_b;
    logic [6:0] dist_a, dist_b;
    logic [1:0] state_a, state_b;
    logic       coll_a, coll_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    vehicle_plant_model #(.TICK_DIV(TICK)) dut_a (
        .CLK             (CLK),
        .rst             (rst),
        .enable          (enable),
        .accelerate_car  (accelerate_car),
        .unlock_doors    (unlock_doors),
        .lead_speed      (lead_speed),
        .car_speed       (speed_a),
        .leading_distance(dist_a),
        .plant_state     (state_a),
        .collision       (coll_a)
    );

    vehicle_plant_model #(.TICK_DIV(TICK), .BRAKE_DIST(0)) dut_b (
        .CLK             (CLK),
        .rst             (rst),
        .enable          (enable),
        .accelerate_car  (accelerate_car),
        .unlock_doors    (unlock_doors),
        .lead_speed      (lead_speed),
        .car_speed       (speed_b),
        .leading_distance(dist_b),
        .plant_state     (state_b),
        .collision       (coll_b)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("  ok   %s = %0d", tag, obs);
        end
    endtask

    // Advance n plant ticks (prescaler assumed at 0, enable held high),
    // then settle 1 time unit past the last edge.
    task automatic run_ticks(input int n);
        repeat (n * TICK) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  found;
        int  exp_spd;
        int  gap_exp[3];

        rst            = 1'b0;
        enable         = 1'b0;
        accelerate_car = 1'b0;
        unlock_doors   = 1'b0;
        lead_speed     = 8'd0;

        // ---------------- reset, then idle with enable low ----------------
        do_reset();
        repeat (10) @(posedge CLK);
        #1;
        check_val("rst_speed", speed_a, 0);
        check_val("rst_dist",  dist_a, 70);
        check_val("rst_state", state_a, ST_PARKED);
        check_val("rst_coll",  coll_a, 0);

        // ---------------- launch: lead 80 ----------------
        // t1: PARKED keeps speed 0, gap +10 -> 80; go ACCEL
        // t2: speed 10, gap +10 (from speed 0) -> 90
        // t3: speed 20, gap +(70>>>3=8) -> 98
        lead_speed     = 8'd80;
        accelerate_car = 1'b1;
        enable         = 1'b1;
        run_ticks(1);
        check_val("launch1_state", state_a, ST_ACCEL);
        check_val("launch1_speed", speed_a, 0);
        check_val("launch1_dist",  dist_a, 80);
        run_ticks(1);
        check_val("launch2_speed", speed_a, 10);
        check_val("launch2_dist",  dist_a, 90);
        run_ticks(1);
        check_val("launch3_speed", speed_a, 20);
        check_val("launch3_dist",  dist_a, 98);

        // ---------------- enable freezes the prescaler mid-count ----------------
        repeat (2) @(posedge CLK);
        #1;
        enable = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check_val("frz_hold_speed", speed_a, 20);
        enable = 1'b1;
        @(posedge CLK);
        #1;
        check_val("frz_pre_speed", speed_a, 20);
        @(posedge CLK);
        #1;
        check_val("frz_tick_speed", speed_a, 30);
        check_val("frz_tick_dist",  dist_a, 105);

        // ---------------- saturation: lead 255 ----------------
        // t1 gap 70+31=101, t2 onward clamps at 127; speed 10*(n-1) up to 200
        lead_speed = 8'd255;
        do_reset();
        for (int n = 1; n <= 25; n++) begin
            run_ticks(1);
            exp_spd = (10 * (n - 1) > 200) ? 200 : 10 * (n - 1);
            check_val($sformatf("sat_t%0d_speed", n), speed_a, exp_spd);
            check_val($sformatf("sat_t%0d_dist", n), dist_a, (n == 1) ? 101 : 127);
        end

        // ---------------- gap brake: lead 190 ----------------
        // The car saturates at 200 and closes 2 m per tick from 127, so the
        // first gap under 20 is 19. The next tick brakes (speed still stepped
        // by ACCEL -> 200, gap 17). Then 180..0 in BRAKE and PARKED after.
        lead_speed = 8'd190;
        do_reset();
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            run_ticks(1);
            if (dist_a < 7'd20) found = 1;
        end
        check_val("gap_found", found, 1);
        check_val("gap_first_dist", dist_a, 19);
        check_val("gap_first_speed", speed_a, 200);
        check_val("gap_first_state", state_a, ST_ACCEL);
        run_ticks(1);
        check_val("gap_brk_state", state_a, ST_BRAKE);
        check_val("gap_brk_speed", speed_a, 200);
        check_val("gap_brk_dist",  dist_a, 17);
        accelerate_car = 1'b0;
        gap_exp[0] = 15;
        gap_exp[1] = 16;
        gap_exp[2] = 19;
        for (int i = 1; i <= 10; i++) begin
            run_ticks(1);
            check_val($sformatf("gap_b%0d_speed", i), speed_a, 200 - 20 * i);
            check_val($sformatf("gap_b%0d_state", i), state_a, ST_BRAKE);
            if (i <= 3) check_val($sformatf("gap_b%0d_dist", i), dist_a, gap_exp[i-1]);
        end
        run_ticks(1);
        check_val("gap_park_state", state_a, ST_PARKED);
        check_val("gap_park_speed", speed_a, 0);
        check_val("gap_coll", coll_a, 0);

        // ---------------- collision on dut_b: lead 0 ----------------
        // gaps 70,70,68,65,61,56,49,41,32,22,10 then 10-13 clamps to 0 at t12
        accelerate_car = 1'b1;
        lead_speed     = 8'd0;
        do_reset();
        run_ticks(11);
        check_val("col_t11_dist",  dist_b, 10);
        check_val("col_t11_speed", speed_b, 100);
        check_val("col_t11_coll",  coll_b, 0);
        run_ticks(1);
        check_val("col_t12_coll",  coll_b, 1);
        check_val("col_t12_dist",  dist_b, 0);
        check_val("col_t12_speed", speed_b, 110);
        check_val("col_t12_state", state_b, ST_ACCEL);
        run_ticks(1);
        check_val("col_t13_state", state_b, ST_BRAKE);
        check_val("col_t13_speed", speed_b, 120);
        for (int i = 1; i <= 6; i++) begin
            run_ticks(1);
            check_val($sformatf("col_b%0d_speed", i), speed_b, 120 - 20 * i);
            check_val($sformatf("col_b%0d_state", i), state_b, ST_BRAKE);
        end
        run_ticks(1);
        check_val("col_park_state", state_b, ST_PARKED);
        for (int i = 0; i < 3; i++) begin
            run_ticks(1);
            check_val($sformatf("col_hold%0d_state", i), state_b, ST_PARKED);
            check_val($sformatf("col_hold%0d_coll", i), coll_b, 1);
        end
        do_reset();
        check_val("col_rst_coll", coll_b, 0);

        // ---------------- doors: lead 80 ----------------
        // gap 80,90,98,105,111,116,119 with speed 60 after t7.
        // Unlock at ACCEL: the tick still steps ACCEL (70) and moves to BRAKE,
        // then 50,30,10,0, then PARKED.
        lead_speed = 8'd80;
        do_reset();
        run_ticks(7);
        check_val("door_pre_speed", speed_a, 60);
        check_val("door_pre_state", state_a, ST_ACCEL);
        check_val("door_pre_dist",  dist_a, 119);
        unlock_doors = 1'b1;
        run_ticks(1);
        check_val("door_brk_state", state_a, ST_BRAKE);
        check_val("door_brk_speed", speed_a, 70);
        for (int i = 1; i <= 4; i++) begin
            run_ticks(1);
            exp_spd = (70 - 20 * i < 0) ? 0 : 70 - 20 * i;
            check_val($sformatf("door_b%0d_speed", i), speed_a, exp_spd);
            check_val($sformatf("door_b%0d_state", i), state_a, ST_BRAKE);
        end
        run_ticks(1);
        check_val("door_park_state", state_a, ST_PARKED);
        for (int i = 0; i < 2; i++) begin
            run_ticks(1);
            check_val($sformatf("door_hold%0d_state", i), state_a, ST_PARKED);
        end

        // ---------------- reset one edge before a tick ----------------
        unlock_doors = 1'b0;
        run_ticks(1);
        check_val("mid_go_state", state_a, ST_ACCEL);
        run_ticks(1);
        check_val("mid_go_speed", speed_a, 10);
        repeat (3) @(posedge CLK);
        #1;
        rst = 1'b1;
        @(posedge CLK);
        #1;
        check_val("mid_rst_speed", speed_a, 0);
        check_val("mid_rst_dist",  dist_a, 70);
        check_val("mid_rst_state", state_a, ST_PARKED);
        check_val("mid_rst_coll",  coll_a, 0);
        rst = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("mid_pre_tick_state", state_a, ST_PARKED);
        @(posedge CLK);
        #1;
        check_val("mid_first_tick_state", state_a, ST_ACCEL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
